accel_axi_rd_master: RTL and testbench

AXI4 read initiator that fills the accelerator's local buffer from system memory. It is the master-side counterpart of the accelerator's AXI slave port and hangs off a spare master port of the AXI node. Software supplies a source address and a word count through the accelerator control registers. The block then issues word-sized INCR bursts and writes each returned beat into the buffer write port.

---
 rtl/accel_axi_rd_master.sv | 222 ++++++++++++++++++++++
 tb/tb_accel_axi_rd_master.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_axi_rd_master.sv
// accel_axi_rd_master
//
// AXI4 read initiator that copies a block of words from system memory into
// the accelerator's local buffer. Software gives a byte source address and a
// word count; the block issues word-sized INCR bursts (one outstanding at a
// time) and writes every OKAY beat into the buffer write port.
//
// Ports
//   clk, rst_n          single clock, synchronous active-low reset
//   start_i             launch request (honoured in IDLE only)
//   src_addr_i          byte source address (low two bits ignored)
//   len_i               transfer length in words, 0..2^BUF_ADDR_WIDTH
//   busy_o              transfer in progress (any state other than IDLE)
//   done_o              one-cycle completion pulse
//   err_o               sticky error, cleared by the next accepted start
//   ar_*                AXI read-address channel (master side)
//   r_*                 AXI read-data channel (master side)
//   buf_we_o/addr/wdata registered buffer write port
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start_i
//   S_ADDR  | ar_valid_o high, burst address/length held until accepted
//   S_DATA  | r_ready_o high, counting beats of the outstanding burst
//   S_DONE  | done_o pulse, back to S_IDLE next cycle

module accel_axi_rd_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 2,
    parameter int AXI_ID         = 0,
    parameter int MAX_BURST      = 16,
    parameter int BUF_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      start_i,
    input  logic [AXI_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [BUF_ADDR_WIDTH:0]   len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,

    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] ar_addr_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic [AXI_ID_WIDTH-1:0]   ar_id_o,

    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   r_id_i,

    output logic                      buf_we_o,
    output logic [BUF_ADDR_WIDTH-1:0] buf_addr_o,
    output logic [AXI_DATA_WIDTH-1:0] buf_wdata_o
);

    localparam int LEN_W = BUF_ADDR_WIDTH + 1;
    // Wide enough for the remaining count and for the 1024-word page size.
    localparam int CW    = (LEN_W > 12) ? LEN_W : 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]          remain_q, remain_d;
    logic [8:0]                beats_q, beats_d;
    logic                      err_q, err_d;
    logic [BUF_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                      buf_we_q, buf_we_d;
    logic [BUF_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [AXI_DATA_WIDTH-1:0] buf_wdata_q, buf_wdata_d;

    logic [CW-1:0] rem_ext;
    logic [CW-1:0] page_left;
    logic [CW-1:0] burst_cap;
    logic [CW-1:0] burst_beats;
    logic          ar_hs;
    logic          r_hs;
    logic          final_beat;
    logic          beat_err;

    // Burst size: min(remaining words, MAX_BURST, words left in the 4 KB page).
    // addr_q only changes on an AR handshake, so this is stable in S_ADDR.
    always_comb begin
        rem_ext     = CW'(remain_q);
        page_left   = CW'(1024) - CW'(addr_q[11:2]);
        burst_cap   = (rem_ext < CW'(MAX_BURST)) ? rem_ext : CW'(MAX_BURST);
        burst_beats = (page_left < burst_cap) ? page_left : burst_cap;
    end

    assign ar_hs      = (state_q == S_ADDR) && ar_ready_i;
    assign r_hs       = (state_q == S_DATA) && r_valid_i;
    assign final_beat = (beats_q == 9'd1);
    // Bad response or r_last_i disagreeing with our own beat count.
    assign beat_err   = (r_resp_i != 2'b00) || (r_last_i != final_beat);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        beats_d     = beats_q;
        err_d       = err_q;
        ptr_d       = ptr_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        addr_d   = {src_addr_i[AXI_ADDR_WIDTH-1:2], 2'b00};
                        remain_d = len_i;
                        ptr_d    = '0;
                        state_d  = S_ADDR;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end

            S_ADDR: begin
                if (ar_hs) begin
                    beats_d = 9'(burst_beats);
                    addr_d  = addr_q + (AXI_ADDR_WIDTH'(burst_beats) << 2);
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (r_hs) begin
                    beats_d  = beats_q - 9'd1;
                    remain_d = remain_q - LEN_W'(1);
                    if (r_resp_i == 2'b00) begin
                        buf_we_d    = 1'b1;
                        buf_addr_d  = ptr_q;
                        buf_wdata_d = r_data_i;
                        ptr_d       = ptr_q + BUF_ADDR_WIDTH'(1);
                    end
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    // The beat count, not r_last_i, closes the burst. Any error
                    // so far (including this beat) stops further ARs.
                    if (final_beat) begin
                        state_d = ((remain_d != '0) && !err_d) ? S_ADDR : S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            beats_q     <= '0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            beats_q     <= beats_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;

    assign ar_valid_o  = (state_q == S_ADDR);
    assign ar_addr_o   = addr_q;
    assign ar_len_o    = (state_q == S_ADDR) ? 8'(burst_beats - CW'(1)) : 8'd0;
    assign ar_size_o   = 3'b010;
    assign ar_burst_o  = 2'b01;
    assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);

    assign r_ready_o   = (state_q == S_DATA);

    assign buf_we_o    = buf_we_q;
    assign buf_addr_o  = buf_addr_q;
    assign buf_wdata_o = buf_wdata_q;

    // Read ID is not needed with a single outstanding burst; the low address
    // bits are forced to word alignment.
    logic unused_ok;
    assign unused_ok = ^{r_id_i, src_addr_i[1:0]};

endmodule

// File: tb/tb_accel_axi_rd_master.sv
module tb_accel_axi_rd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [10:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic        ar_valid_o;
    logic        ar_ready_i = 1'b0;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic [1:0]  ar_id_o;
    logic        r_valid_i = 1'b0;
    logic        r_ready_o;
    logic [31:0] r_data_i = '0;
    logic [1:0]  r_resp_i = '0;
    logic        r_last_i = 1'b0;
    logic [1:0]  r_id_i = '0;
    logic        buf_we_o;
    logic [9:0]  buf_addr_o;
    logic [31:0] buf_wdata_o;

    accel_axi_rd_master dut (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_i), .src_addr_i(src_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_id_i(r_id_i),
        .buf_we_o(buf_we_o), .buf_addr_o(buf_addr_o), .buf_wdata_o(buf_wdata_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave behaviour knobs
    int          ar_delay = 0;
    bit          r_gaps = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] last_flip_addr = 32'hFFFF_FFFF;

    // Monitor records
    logic [31:0] mon_ar_addr[$];
    logic [7:0]  mon_ar_len[$];
    logic [2:0]  mon_ar_size[$];
    logic [1:0]  mon_ar_burst[$];
    logic [1:0]  mon_ar_id[$];
    logic [9:0]  mon_wr_addr[$];
    logic [31:0] mon_wr_data[$];
    int          mon_done = 0;
    int          mon_stab_err = 0;
    int          mon_rok = 0;
    logic        mon_done_we = 1'b0;
    logic [9:0]  mon_done_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    // Memory-side slave: accepts AR after ar_delay cycles, returns len+1 beats.
    initial begin : slave
        logic [31:0] a;
        logic [7:0]  l;
        logic [31:0] ba;
        forever begin
            @(negedge clk);
            if (rst_n && ar_valid_o) begin
                for (int i = 0; i < ar_delay; i++) @(negedge clk);
                ar_ready_i = 1'b1;
                a = ar_addr_o;
                l = ar_len_o;
                @(negedge clk);
                ar_ready_i = 1'b0;
                for (int b = 0; b <= int'(l); b++) begin
                    if (!rst_n) break;
                    while (r_gaps && rst_n && ($urandom_range(0, 2) == 0)) @(negedge clk);
                    ba        = a + 32'(4 * b);
                    r_valid_i = 1'b1;
                    r_data_i  = mem_word(ba);
                    r_resp_i  = (ba == err_addr) ? 2'd2 : 2'd0;
                    r_last_i  = (b == int'(l)) != (ba == last_flip_addr);
                    @(negedge clk);
                    r_valid_i = 1'b0;
                    r_last_i  = 1'b0;
                    r_resp_i  = 2'd0;
                end
            end
        end
    end

    // Observes each cycle between edges, after the slave has driven.
    initial begin : monitor
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        prev_wait = 1'b0;
        prev_addr = '0;
        prev_len  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && (!ar_valid_o || ar_addr_o !== prev_addr || ar_len_o !== prev_len))
                    mon_stab_err++;
                prev_wait = ar_valid_o && !ar_ready_i;
                prev_addr = ar_addr_o;
                prev_len  = ar_len_o;
                if (ar_valid_o && ar_ready_i) begin
                    mon_ar_addr.push_back(ar_addr_o);
                    mon_ar_len.push_back(ar_len_o);
                    mon_ar_size.push_back(ar_size_o);
                    mon_ar_burst.push_back(ar_burst_o);
                    mon_ar_id.push_back(ar_id_o);
                end
                if (buf_we_o) begin
                    mon_wr_addr.push_back(buf_addr_o);
                    mon_wr_data.push_back(buf_wdata_o);
                end
                if (r_valid_i && r_ready_o && r_resp_i == 2'd0) mon_rok++;
                if (done_o) begin
                    mon_done++;
                    mon_done_we   = buf_we_o;
                    mon_done_addr = buf_addr_o;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        mon_ar_addr.delete(); mon_ar_len.delete(); mon_ar_size.delete();
        mon_ar_burst.delete(); mon_ar_id.delete();
        mon_wr_addr.delete(); mon_wr_data.delete();
        mon_done = 0; mon_stab_err = 0; mon_rok = 0;
        mon_done_we = 1'b0; mon_done_addr = '0;
    endtask

    // Drives start_i in cycle 0; returns at the falling edge of cycle 1.
    task automatic do_start(input logic [31:0] a, input logic [10:0] n);
        @(negedge clk);
        start_i    = 1'b1;
        src_addr_i = a;
        len_i      = n;
        @(negedge clk);
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (mon_done != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({busy_o, done_o, err_o, ar_valid_o, r_ready_o, buf_we_o} !== 6'b0)
            begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 000000", {busy_o, done_o, err_o, ar_valid_o, r_ready_o, buf_we_o}); end
        tests_run++;
        if (ar_addr_o !== 32'h0 || ar_len_o !== 8'h0 || buf_addr_o !== 10'h0 || buf_wdata_o !== 32'h0)
            begin tests_failed++; $display("FAIL reset_data: ar_addr %h ar_len %h buf_addr %h wdata %h expected zeros", ar_addr_o, ar_len_o, buf_addr_o, buf_wdata_o); end
        tests_run++;
        if (ar_size_o !== 3'b010 || ar_burst_o !== 2'b01 || ar_id_o !== 2'b00)
            begin tests_failed++; $display("FAIL reset_const: size %b burst %b id %b expected 010 01 00", ar_size_o, ar_burst_o, ar_id_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        bit to;
        clear_mon();
        do_start(32'h0000_1000, 11'd5);
        #1;
        tests_run++;
        if (ar_valid_o !== 1'b1 || busy_o !== 1'b1)
            begin tests_failed++; $display("FAIL single_cycle1: ar_valid %b busy %b expected 1 1", ar_valid_o, busy_o); end
        wait_done(200, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL single_timeout: done not seen"); end
        tests_run++;
        if (mon_ar_addr.size() !== 1) begin tests_failed++; $display("FAIL single_ar_count: got %0d expected 1", mon_ar_addr.size()); end
        else begin
            tests_run++;
            if (mon_ar_addr[0] !== 32'h1000 || mon_ar_len[0] !== 8'd4 || mon_ar_size[0] !== 3'd2 || mon_ar_burst[0] !== 2'd1 || mon_ar_id[0] !== 2'd0)
                begin tests_failed++; $display("FAIL single_ar: addr %h len %0d size %0d burst %0d id %0d expected 1000 4 2 1 0", mon_ar_addr[0], mon_ar_len[0], mon_ar_size[0], mon_ar_burst[0], mon_ar_id[0]); end
        end
        tests_run++;
        if (mon_wr_addr.size() !== 5) begin tests_failed++; $display("FAIL single_wr_count: got %0d expected 5", mon_wr_addr.size()); end
        for (int i = 0; i < mon_wr_addr.size() && i < 5; i++) begin
            tests_run++;
            if (mon_wr_addr[i] !== 10'(i) || mon_wr_data[i] !== mem_word(32'h1000 + 32'(4 * i)))
                begin tests_failed++; $display("FAIL single_wr%0d: addr %0d data %h expected %0d %h", i, mon_wr_addr[i], mon_wr_data[i], i, mem_word(32'h1000 + 32'(4 * i))); end
        end
        tests_run++;
        if (mon_done !== 1 || mon_done_we !== 1'b1 || mon_done_addr !== 10'd4)
            begin tests_failed++; $display("FAIL single_done: count %0d we %b addr %0d expected 1 1 4", mon_done, mon_done_we, mon_done_addr); end
        tests_run++;
        if (err_o !== 1'b0 || busy_o !== 1'b0)
            begin tests_failed++; $display("FAIL single_end: err %b busy %b expected 0 0", err_o, busy_o); end
    endtask

    task automatic test_burst_split();
        bit to;
        logic [31:0] ea [3];
        logic [7:0]  el [3];
        ea = '{32'h2000_0000, 32'h2000_0040, 32'h2000_0080};
        el = '{8'd15, 8'd15, 8'd7};
        clear_mon();
        do_start(32'h2000_0000, 11'd40);
        wait_done(400, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL split_timeout: done not seen"); end
        tests_run++;
        if (mon_ar_addr.size() !== 3) begin tests_failed++; $display("FAIL split_ar_count: got %0d expected 3", mon_ar_addr.size()); end
        for (int i = 0; i < 3 && i < mon_ar_addr.size(); i++) begin
            tests_run++;
            if (mon_ar_addr[i] !== ea[i] || mon_ar_len[i] !== el[i])
                begin tests_failed++; $display("FAIL split_ar%0d: addr %h len %0d expected %h %0d", i, mon_ar_addr[i], mon_ar_len[i], ea[i], el[i]); end
        end
        tests_run++;
        if (mon_wr_addr.size() !== 40) begin tests_failed++; $display("FAIL split_wr_count: got %0d expected 40", mon_wr_addr.size()); end
        for (int i = 0; i < mon_wr_addr.size() && i < 40; i++) begin
            tests_run++;
            if (mon_wr_addr[i] !== 10'(i) || mon_wr_data[i] !== mem_word(32'h2000_0000 + 32'(4 * i)))
                begin tests_failed++; $display("FAIL split_wr%0d: addr %0d data %h", i, mon_wr_addr[i], mon_wr_data[i]); end
        end
    endtask

    task automatic test_4kb_boundary();
        bit to;
        clear_mon();
        do_start(32'h0000_0FF8, 11'd6);
        wait_done(200, to);
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL page_timeout: done not seen"); end
        tests_run++;
        if (mon_ar_addr.size() !== 2) begin tests_failed++; $display("FAIL page_ar_count: got %0d expected 2", mon_ar_addr.size()); end
        else begin
            tests_run++;
            if (mon_ar_addr[0] !== 32'h0FF8 || mon_ar_len[0] !== 8'd1 || mon_ar_addr[1] !== 32'h1000 || mon_ar_len[1] !== 8'd3)
                begin tests_failed++; $display("FAIL page_ar: %h/%0d %h/%0d expected 0ff8/1 1000/3", mon_ar_addr[0], mon_ar_len[0], mon_ar_addr[1], mon_ar_len[1]); end
        end
        tests_run++;
        if (mon_wr_addr.size() !== 6) begin tests_failed++; $display("FAIL page_wr_count: got %0d expected 6", mon_wr_addr.size()); end
        for (int i = 0; i < mon_wr_addr.size() && i < 6; i++) begin
            tests_run++;
            if (mon_wr_addr[i] !== 10'(i) || mon_wr_data[i] !== mem_word(32'h0FF8 + 32'(4 * i)))
                begin tests_failed++; $display("FAIL page_wr%0d: addr %0d data %h", i, mon_wr_addr[i], mon_wr_data[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_mon();
        ar_delay = 3;
        r_gaps   = 1'b1;
        do_start(32'h3000_0010, 11'd20);
        wait_done(2000, to);
        ar_delay = 0;
        r_gaps   = 1'b0;
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: done not seen"); end
        tests_run++;
        if (mon_stab_err !== 0) begin tests_failed++; $display("FAIL bp_ar_stable: %0d unstable cycles expected 0", mon_stab_err); end
        tests_run++;
        if (mon_ar_addr.size() !== 2) begin tests_failed++; $display("FAIL bp_ar_count: got %0d expected 2", mon_ar_addr.size()); end
        else begin
            tests_run++;
            if (mon_ar_addr[0] !== 32'h3000_0010 || mon_ar_len[0] !== 8'd15 || mon_ar_addr[1] !== 32'h3000_0050 || mon_ar_len[1] !== 8'd3)
                begin tests_failed++; $display("FAIL bp_ar: %h/%0d %h/%0d expected 30000010/15 30000050/3", mon_ar_addr[0], mon_ar_len[0], mon_ar_addr[1], mon_ar_len[1]); end
        end
        tests_run++;
        if (mon_wr_addr.size() !== 20 || mon_rok !== 20)
            begin tests_failed++; $display("FAIL bp_wr_count: writes %0d handshakes %0d expected 20 20", mon_wr_addr.size(), mon_rok); end
        for (int i = 0; i < mon_wr_addr.size() && i < 20; i++) begin
            tests_run++;
            if (mon_wr_addr[i] !== 10'(i) || mon_wr_data[i] !== mem_word(32'h3000_0010 + 32'(4 * i)))
                begin tests_failed++; $display("FAIL bp_wr%0d: addr %0d data %h", i, mon_wr_addr[i], mon_wr_data[i]); end
        end
    endtask

    task automatic test_error_response();
        bit to;
        int beat;
        clear_mon();
        err_addr = 32'h4000_0008;
        do_start(32'h4000_0000, 11'd40);
        wait_done(400, to);
        err_addr = 32'hFFFF_FFFF;
        tests_run++;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL err_timeout: done not seen"); end
        tests_run++;
        if (err_o !== 1'b1) begin tests_failed++; $display("FAIL err_flag: got %b expected 1", err_o); end
        tests_run++;
        if (mon_ar_addr.size() !== 1 || mon_done !== 1)
            begin tests_failed++; $display("FAIL err_ar_done: ar %0d done %0d expected 1 1", mon_ar_addr.size(), mon_done); end
        tests_run++;
        if (mon_wr_addr.size() !== 15) begin tests_failed++; $display("FAIL err_wr_count: got %0d expected 15", mon_wr_addr.size()); end
        for (int k = 0; k < mon_wr_addr.size() && k < 15; k++) begin
            beat = (k < 2) ? k : k + 1;
            tests_run++;
            if (mon_wr_addr[k] !== 10'(k) || mon_wr_data[k] !== mem_word(32'h4000_0000 + 32'(4 * beat)))
                begin tests_failed++; $display("FAIL err_wr%0d: addr %0d data %h expected %0d %h", k, mon_wr_addr[k], mon_wr_data[k], k, mem_word(32'h4000_0000 + 32'(4 * beat))); end
        end
        clear_mon();
        do_start(32'h5000_0000, 11'd3);
        #1;
        tests_run++;
        if (err_o !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", err_o); end
        wait_done(200, to);
        tests_run++;
        if (to !== 1'b0 || err_o !== 1'b0 || mon_wr_addr.size() !== 3)
            begin tests_failed++; $display("FAIL err_recover: timeout %b err %b writes %0d expected 0 0 3", to, err_o, mon_wr_addr.size()); end
    endtask

    task automatic test_last_mismatch();
        bit to;
        clear_mon();
        last_flip_addr = 32'h6000_0004;
        do_start(32'h6000_0000, 11'd4);
        wait_done(200, to);
        tests_run++;
        if (to !== 1'b0 || err_o !== 1'b1 || mon_ar_addr.size() !== 1 || mon_wr_addr.size() !== 4)
            begin tests_failed++; $display("FAIL last_early: timeout %b err %b ar %0d writes %0d expected 0 1 1 4", to, err_o, mon_ar_addr.size(), mon_wr_addr.size()); end
        clear_mon();
        last_flip_addr = 32'h6100_003C;
        do_start(32'h6100_0000, 11'd20);
        wait_done(300, to);
        last_flip_addr = 32'hFFFF_FFFF;
        tests_run++;
        if (to !== 1'b0 || err_o !== 1'b1 || mon_ar_addr.size() !== 1 || mon_wr_addr.size() !== 16)
            begin tests_failed++; $display("FAIL last_missing: timeout %b err %b ar %0d writes %0d expected 0 1 1 16", to, err_o, mon_ar_addr.size(), mon_wr_addr.size()); end
    endtask

    task automatic test_start_ignored();
        bit to;
        bit seen;
        clear_mon();
        do_start(32'h7000_0000, 11'd10);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = r_ready_o;
        end
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL ign_reach_data: r_ready never seen"); end
        start_i    = 1'b1;
        src_addr_i = 32'hABC0_0000;
        len_i      = 11'd7;
        @(negedge clk);
        start_i    = 1'b0;
        wait_done(200, to);
        repeat (5) @(negedge clk);
        #3;
        tests_run++;
        if (to !== 1'b0 || mon_done !== 1 || mon_ar_addr.size() !== 1 || mon_wr_addr.size() !== 10)
            begin tests_failed++; $display("FAIL ign_counts: timeout %b done %0d ar %0d writes %0d expected 0 1 1 10", to, mon_done, mon_ar_addr.size(), mon_wr_addr.size()); end
        tests_run++;
        if (busy_o !== 1'b0 || err_o !== 1'b0)
            begin tests_failed++; $display("FAIL ign_idle: busy %b err %b expected 0 0", busy_o, err_o); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        do_start(32'h1234_5678, 11'd0);
        #1;
        tests_run++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || ar_valid_o !== 1'b0)
            begin tests_failed++; $display("FAIL zero_cycle1: done %b busy %b ar_valid %b expected 1 1 0", done_o, busy_o, ar_valid_o); end
        @(negedge clk);
        #1;
        tests_run++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
            begin tests_failed++; $display("FAIL zero_cycle2: done %b busy %b expected 0 0", done_o, busy_o); end
        repeat (3) @(negedge clk);
        #3;
        tests_run++;
        if (mon_ar_addr.size() !== 0 || mon_wr_addr.size() !== 0 || mon_done !== 1)
            begin tests_failed++; $display("FAIL zero_traffic: ar %0d writes %0d done %0d expected 0 0 1", mon_ar_addr.size(), mon_wr_addr.size(), mon_done); end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        bit seen;
        clear_mon();
        do_start(32'h8000_0000, 11'd16);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #3;
            seen = (mon_wr_addr.size() >= 3);
        end
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_progress: fewer than 3 writes seen"); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({busy_o, done_o, err_o, ar_valid_o, r_ready_o, buf_we_o} !== 6'b0 || buf_addr_o !== 10'h0 || buf_wdata_o !== 32'h0 || ar_addr_o !== 32'h0 || ar_len_o !== 8'h0)
            begin tests_failed++; $display("FAIL rst_mid_outputs: ctrl %b buf_addr %h wdata %h ar_addr %h ar_len %h expected zeros", {busy_o, done_o, err_o, ar_valid_o, r_ready_o, buf_we_o}, buf_addr_o, buf_wdata_o, ar_addr_o, ar_len_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        do_start(32'h9000_0000, 11'd2);
        wait_done(200, to);
        tests_run++;
        if (to !== 1'b0 || mon_wr_addr.size() !== 2 || mon_ar_addr.size() !== 1)
            begin tests_failed++; $display("FAIL rst_mid_restart: timeout %b writes %0d ar %0d expected 0 2 1", to, mon_wr_addr.size(), mon_ar_addr.size()); end
        else begin
            tests_run++;
            if (mon_wr_addr[0] !== 10'd0 || mon_wr_addr[1] !== 10'd1 || mon_wr_data[1] !== mem_word(32'h9000_0004))
                begin tests_failed++; $display("FAIL rst_mid_ptr: addrs %0d %0d data %h expected 0 1 %h", mon_wr_addr[0], mon_wr_addr[1], mon_wr_data[1], mem_word(32'h9000_0004)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_burst_split();
        test_4kb_boundary();
        test_backpressure();
        test_error_response();
        test_last_mismatch();
        test_start_ignored();
        test_zero_len();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
